// File: rtl/am_mod_gen2_if.sv
// rtl/am_mod_gen2_if.sv - sample/control bundle between sine generators, AM modulator and DAC path
interface am_mod_gen2_if #(
    parameter int DW = 12,
    parameter int IW = 8
);
    logic                 pls;
    logic                 mode;
    logic [IW-1:0]        indx_set;
    logic signed [DW-1:0] carrier;
    logic signed [DW-1:0] source;
    logic signed [DW-1:0] mod_out;
    logic                 mod_vld;
    logic                 ovm;
    logic                 sat;
    logic [IW-1:0]        indx_cur;
    logic                 ramp_busy;

    modport master (
        output pls, mode, indx_set, carrier, source,
        input  mod_out, mod_vld, ovm, sat, indx_cur, ramp_busy
    );

    modport slave (
        input  pls, mode, indx_set, carrier, source,
        output mod_out, mod_vld, ovm, sat, indx_cur, ramp_busy
    );
endinterface

// File: rtl/am_mod_gen2.sv
// rtl/am_mod_gen2.sv - parametrised DSB-FC / DSB-SC AM modulator with slew-limited index
module am_mod_gen2 #(
    parameter int DW   = 12,
    parameter int IW   = 8,
    parameter int RAMP = 1
) (
    input  logic          clk,
    input  logic          rst,
    am_mod_gen2_if.slave  bus
);
    // Scaled-source / envelope width and the carrier*envelope product width
    localparam int SCW = DW + 2;
    localparam int P1W = DW + IW + 1;
    localparam int P3W = DW + SCW;

    // Full-scale carrier offset added to the scaled message in DSB-FC mode
    localparam logic signed [SCW-1:0] CAR_OFS = SCW'(1 << (DW - 1));
    localparam logic signed [P3W-1:0] OUT_MAX = P3W'((1 << (DW - 1)) - 1);
    localparam logic signed [P3W-1:0] OUT_MIN = P3W'(-(1 << (DW - 1)));

    typedef enum logic [1:0] {R_IDLE, R_UP, R_DN} ramp_t;

    logic [IW-1:0] m_eff;

    generate
        if (RAMP != 0) begin : g_ramp
            ramp_t         rstate;
            logic [IW-1:0] m_cur;
            logic          up_req;
            logic          dn_req;

            assign up_req = bus.indx_set > m_cur;
            assign dn_req = bus.indx_set < m_cur;

            // Index slew FSM: one LSB per strobe toward the (possibly moving) target, never wrapping
            always_ff @(posedge clk) begin
                if (rst) begin
                    m_cur  <= '0;
                    rstate <= R_IDLE;
                end else if (bus.pls) begin
                    unique case (rstate)
                        R_UP: begin
                            if (up_req) begin
                                m_cur  <= m_cur + 1'b1;
                                rstate <= (bus.indx_set == m_cur + 1'b1) ? R_IDLE : R_UP;
                            end else if (dn_req) begin
                                m_cur  <= m_cur - 1'b1;
                                rstate <= (bus.indx_set == m_cur - 1'b1) ? R_IDLE : R_DN;
                            end else begin
                                rstate <= R_IDLE;
                            end
                        end
                        R_DN: begin
                            if (dn_req) begin
                                m_cur  <= m_cur - 1'b1;
                                rstate <= (bus.indx_set == m_cur - 1'b1) ? R_IDLE : R_DN;
                            end else if (up_req) begin
                                m_cur  <= m_cur + 1'b1;
                                rstate <= (bus.indx_set == m_cur + 1'b1) ? R_IDLE : R_UP;
                            end else begin
                                rstate <= R_IDLE;
                            end
                        end
                        default: begin
                            if (up_req) begin
                                m_cur  <= m_cur + 1'b1;
                                rstate <= (bus.indx_set == m_cur + 1'b1) ? R_IDLE : R_UP;
                            end else if (dn_req) begin
                                m_cur  <= m_cur - 1'b1;
                                rstate <= (bus.indx_set == m_cur - 1'b1) ? R_IDLE : R_DN;
                            end else begin
                                rstate <= R_IDLE;
                            end
                        end
                    endcase
                end
            end

            assign m_eff         = m_cur;
            assign bus.ramp_busy = (m_cur != bus.indx_set);
        end else begin : g_direct
            assign m_eff         = bus.indx_set;
            assign bus.ramp_busy = 1'b0;
        end
    endgenerate

    assign bus.indx_cur = m_eff;

    logic signed [SCW-1:0] s1_sc;
    logic signed [DW-1:0]  s1_car;
    logic signed [SCW-1:0] s2_env;
    logic signed [DW-1:0]  s2_car;
    logic                  s2_ovm;
    logic                  s2_sc_mode;
    logic [1:0]            prime;

    logic signed [P1W-1:0] src_x;
    logic signed [P1W-1:0] idx_x;
    logic signed [P1W-1:0] prod1;
    logic signed [SCW-1:0] sc_next;
    logic signed [SCW-1:0] env_next;
    logic signed [P3W-1:0] car_x;
    logic signed [P3W-1:0] env_x;
    logic signed [P3W-1:0] prod3;
    logic signed [P3W-1:0] p;

    // Datapath arithmetic: scale message by index, form envelope, multiply onto carrier
    always_comb begin
        src_x    = {{(IW + 1){bus.source[DW-1]}}, bus.source};
        idx_x    = {{(DW + 1){1'b0}}, m_eff};
        prod1    = src_x * idx_x;
        sc_next  = SCW'(prod1 >>> (IW - 1));
        env_next = bus.mode ? s1_sc : (CAR_OFS + s1_sc);
        car_x    = {{SCW{s2_car[DW-1]}}, s2_car};
        env_x    = {{DW{s2_env[SCW-1]}}, s2_env};
        prod3    = car_x * env_x;
        p        = s2_sc_mode ? (prod3 >>> (DW - 1)) : (prod3 >>> DW);
    end

    // Three-stage sample pipeline, advanced only on the sample strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sc       <= '0;
            s1_car      <= '0;
            s2_env      <= '0;
            s2_car      <= '0;
            s2_ovm      <= 1'b0;
            s2_sc_mode  <= 1'b0;
            bus.mod_out <= '0;
            bus.sat     <= 1'b0;
            bus.ovm     <= 1'b0;
        end else if (bus.pls) begin
            s1_sc      <= sc_next;
            s1_car     <= bus.carrier;
            s2_env     <= env_next;
            s2_car     <= s1_car;
            s2_ovm     <= !bus.mode && (env_next < 0);
            s2_sc_mode <= bus.mode;
            if (p > OUT_MAX) begin
                bus.mod_out <= DW'(OUT_MAX);
                bus.sat     <= 1'b1;
            end else if (p < OUT_MIN) begin
                bus.mod_out <= DW'(OUT_MIN);
                bus.sat     <= 1'b1;
            end else begin
                bus.mod_out <= DW'(p);
                bus.sat     <= 1'b0;
            end
            bus.ovm <= s2_ovm;
        end
    end

    // Priming counter: the valid pulse starts once three strobes have filled the pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            prime       <= '0;
            bus.mod_vld <= 1'b0;
        end else if (bus.pls) begin
            if (prime != 2'd2) begin
                prime <= prime + 1'b1;
            end
            bus.mod_vld <= (prime == 2'd2);
        end else begin
            bus.mod_vld <= 1'b0;
        end
    end
endmodule

// File: tb/tb_am_mod_gen2.sv
// tb/tb_am_mod_gen2.sv - self-checking bench for am_mod_gen2 (direct and ramped index instances)
module tb_am_mod_gen2;
    localparam int DW = 12;
    localparam int IW = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 pls = 1'b0;
    logic                 mode = 1'b0;
    logic [IW-1:0]        indx_set = '0;
    logic signed [DW-1:0] carrier = '0;
    logic signed [DW-1:0] source = '0;

    am_mod_gen2_if #(.DW(DW), .IW(IW)) if0 ();
    am_mod_gen2_if #(.DW(DW), .IW(IW)) if1 ();

    assign if0.pls      = pls;
    assign if0.mode     = mode;
    assign if0.indx_set = indx_set;
    assign if0.carrier  = carrier;
    assign if0.source   = source;
    assign if1.pls      = pls;
    assign if1.mode     = mode;
    assign if1.indx_set = indx_set;
    assign if1.carrier  = carrier;
    assign if1.source   = source;

    am_mod_gen2 #(.DW(DW), .IW(IW), .RAMP(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    am_mod_gen2 #(.DW(DW), .IW(IW), .RAMP(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic am_model(input int src, input int car, input int m, input int md,
                            output int o, output int s, output int ov);
        int sc;
        int env;
        int p;
        int hi;
        int lo;
        hi  = (1 << (DW - 1)) - 1;
        lo  = -(1 << (DW - 1));
        sc  = fdiv(src * m, 1 << (IW - 1));
        env = (md != 0) ? sc : ((1 << (DW - 1)) + sc);
        ov  = (md == 0 && env < 0) ? 1 : 0;
        p   = fdiv(car * env, (md != 0) ? (1 << (DW - 1)) : (1 << DW));
        if (p > hi) begin
            o = hi; s = 1;
        end else if (p < lo) begin
            o = lo; s = 1;
        end else begin
            o = p; s = 0;
        end
    endtask

    typedef struct {
        int src;
        int car;
        int m0;
        int m1;
        int md;
    } rec_t;

    rec_t hist[$];
    rec_t r;
    int m_model = 0;
    int exp_vld = 0;
    int exp_out0 = 0, exp_sat0 = 0, exp_ovm0 = 0;
    int exp_out1 = 0, exp_sat1 = 0, exp_ovm1 = 0;

    // Reference model: each strobe records a sample; the output after strobe k is the
    // sample of strobe k-2 processed with the mode presented at strobe k-1.
    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            m_model  = 0;
            exp_vld  = 0;
            exp_out0 = 0; exp_sat0 = 0; exp_ovm0 = 0;
            exp_out1 = 0; exp_sat1 = 0; exp_ovm1 = 0;
        end else begin
            exp_vld = 0;
            if (pls) begin
                r.src = int'(source);
                r.car = int'(carrier);
                r.m0  = int'(indx_set);
                r.m1  = m_model;
                r.md  = int'(mode);
                hist.push_back(r);
                if (hist.size() >= 3) begin
                    am_model(hist[0].src, hist[0].car, hist[0].m0, hist[1].md,
                             exp_out0, exp_sat0, exp_ovm0);
                    am_model(hist[0].src, hist[0].car, hist[0].m1, hist[1].md,
                             exp_out1, exp_sat1, exp_ovm1);
                    exp_vld = 1;
                    void'(hist.pop_front());
                end
                if (int'(indx_set) > m_model) m_model++;
                else if (int'(indx_set) < m_model) m_model--;
            end
        end
    end

    int vld_cnt = 0;
    always @(negedge clk) if (if0.mod_vld) vld_cnt++;

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("vld0", int'(if0.mod_vld), exp_vld);
            chk("out0", int'(if0.mod_out), exp_out0);
            chk("sat0", int'(if0.sat), exp_sat0);
            chk("ovm0", int'(if0.ovm), exp_ovm0);
            chk("icur0", int'(if0.indx_cur), int'(indx_set));
            chk("busy0", int'(if0.ramp_busy), 0);
            chk("vld1", int'(if1.mod_vld), exp_vld);
            chk("out1", int'(if1.mod_out), exp_out1);
            chk("sat1", int'(if1.sat), exp_sat1);
            chk("ovm1", int'(if1.ovm), exp_ovm1);
            chk("icur1", int'(if1.indx_cur), m_model);
            chk("busy1", int'(if1.ramp_busy), (m_model != int'(indx_set)) ? 1 : 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1 pls = 1'b1;
        @(posedge clk);
        #1 pls = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_in(input int src, input int car, input int m, input int md);
        source   = DW'(src);
        carrier  = DW'(car);
        indx_set = IW'(m);
        mode     = md[0];
    endtask

    int tsrc[6] = '{-2048, 1000, -700, 2047, -1, 123};
    int tcar[6] = '{2047, -1500, 1234, -2048, 5, -77};
    int tm[6]   = '{255, 200, 64, 255, 1, 0};
    int tmd[6]  = '{1, 0, 1, 0, 1, 0};
    int o, s, v, base;

    initial begin
        set_in(0, 1000, 128, 0);
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        am_model(0, 1000, 128, 0, o, s, v);
        chk("pin_fc_out", o, 500);
        am_model(-2048, 2047, 255, 0, o, s, v);
        chk("pin_ovm_out", o, -1016);
        chk("pin_ovm_flag", v, 1);
        am_model(2047, 2047, 255, 1, o, s, v);
        chk("pin_sat_out", o, 2047);
        chk("pin_sat_flag", s, 1);

        base = vld_cnt;
        step();
        step();
        chk("t1_novld", vld_cnt - base, 0);
        chk("t1_out", int'(if0.mod_out), 0);
        step();
        chk("t1_vld", vld_cnt - base, 1);
        chk("t2_out", int'(if0.mod_out), 500);
        chk("t2_sat", int'(if0.sat), 0);
        chk("t2_ovm", int'(if0.ovm), 0);

        set_in(1024, -1000, 128, 1);
        repeat (3) step();
        chk("t3_out", int'(if0.mod_out), -500);

        set_in(-2048, 2047, 255, 0);
        repeat (3) step();
        chk("t4_out", int'(if0.mod_out), -1016);
        chk("t4_ovm", int'(if0.ovm), 1);
        chk("t4_sat", int'(if0.sat), 0);

        set_in(2047, 2047, 255, 1);
        repeat (3) step();
        chk("t5_out", int'(if0.mod_out), 2047);
        chk("t5_sat", int'(if0.sat), 1);

        for (int i = 0; i < 6; i++) begin
            set_in(tsrc[i], tcar[i], tm[i], tmd[i]);
            step();
        end
        repeat (2) step();

        do_reset();
        indx_set = 8'd10;
        #1;
        chk("t6_cur0", int'(if1.indx_cur), 0);
        chk("t6_busy0", int'(if1.ramp_busy), 1);
        base = vld_cnt;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("t6_cur", int'(if1.indx_cur), k);
            chk("t6_busy", int'(if1.ramp_busy), (k != 10) ? 1 : 0);
            if (k == 2) chk("t6_reprime", vld_cnt - base, 0);
        end

        do_reset();
        indx_set = 8'd10;
        repeat (7) step();
        chk("t6_at7", int'(if1.indx_cur), 7);
        indx_set = 8'd4;
        #1;
        chk("t6_rev_busy", int'(if1.ramp_busy), 1);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("t6_rev_cur", int'(if1.indx_cur), 7 - k);
        end
        chk("t6_rev_done", int'(if1.ramp_busy), 0);

        indx_set = 8'd200;
        repeat (5) step();
        chk("t6_up9", int'(if1.indx_cur), 9);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rst_cur", int'(if1.indx_cur), 0);
        chk("t6_rst_busy", int'(if1.ramp_busy), 1);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
